// File: rtl/core_pkg.sv
// Shared core definitions: LSU funct3 codes, LSU error codes and
// the LSU state encoding. Imported by the core and by the LSU.
package core_pkg;

    // RISC-V load/store width and sign codes (funct3)
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_D  = 3'd3;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    localparam logic [2:0] F3_WU = 3'd6;

    // Completion error codes
    typedef logic [1:0] lsu_err_t;
    localparam lsu_err_t ERR_NONE     = 2'b00;
    localparam lsu_err_t ERR_MISALIGN = 2'b01;
    localparam lsu_err_t ERR_TIMEOUT  = 2'b10;
    localparam lsu_err_t ERR_FUNCT3   = 2'b11;

    // LSU controller states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Purely combinational lane logic for the LSU: byte enables, store-data
// lane replication and load-data extraction with sign/zero extension.
module lsu_align
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NB    = XLEN / 8,
    parameter int OFF_W = $clog2(NB)
) (
    input  logic [2:0]       funct3_i,
    input  logic [OFF_W-1:0] offset_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic [XLEN-1:0]  rdata_i,
    output logic [NB-1:0]    be_o,
    output logic [XLEN-1:0]  wdata_o,
    output logic [XLEN-1:0]  rdata_o
);

    logic [NB-1:0]   size_mask;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep;
    logic            sign_bit;

    // Size mask, replicated store data and extended load data
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case statements can infer a latch.
        size_mask = '1;
        wdata_o   = wdata_i;
        keep      = '1;
        shifted   = rdata_i >> {offset_i, 3'b000};
        sign_bit  = shifted[XLEN-1];
        case (funct3_i[1:0])
            2'd0: begin
                size_mask = NB'(1);
                wdata_o   = {(XLEN/8){wdata_i[7:0]}};
                keep      = XLEN'(8'hFF);
                sign_bit  = shifted[7];
            end
            2'd1: begin
                size_mask = NB'(3);
                wdata_o   = {(XLEN/16){wdata_i[15:0]}};
                keep      = XLEN'(16'hFFFF);
                sign_bit  = shifted[15];
            end
            2'd2: begin
                size_mask = NB'(4'hF);
                wdata_o   = {(XLEN/32){wdata_i[31:0]}};
                keep      = XLEN'(32'hFFFF_FFFF);
                sign_bit  = shifted[31];
            end
            default: ;
        endcase
        be_o = size_mask << offset_i;
        // funct3[2] selects zero-extension; a full-width access leaves ~keep empty
        rdata_o = (shifted & keep) | ((!funct3_i[2] && sign_bit) ? ~keep : '0);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request at a time, decodes legality
// and alignment, runs a req/gnt + rvalid memory handshake with a timeout
// and returns a one-cycle response pulse.
module load_store_unit
    import core_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    output logic                 rsp_valid,
    output logic [XLEN-1:0]      rsp_rdata,
    output logic                 rsp_err,
    output logic [1:0]           rsp_err_code,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    output logic [XLEN/8-1:0]    mem_be,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [XLEN-1:0]      mem_rdata
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_e        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    lsu_err_t          err_q, err_d;

    logic              legal, misaligned;
    lsu_err_t          dec_err;
    logic [8:0]        cnt_inc;
    logic              timed_out;
    logic [NB-1:0]     align_be;
    logic [XLEN-1:0]   align_wdata, align_rdata;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3_i (f3_q),
        .offset_i (addr_q[OFF_W-1:0]),
        .wdata_i  (wdata_q),
        .rdata_i  (mem_rdata),
        .be_o     (align_be),
        .wdata_o  (align_wdata),
        .rdata_o  (align_rdata)
    );

    // Decode the incoming request: illegal funct3 outranks misalignment
    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_D:             legal = (XLEN == 64);
            F3_BU, F3_HU:     legal = !req_we;
            F3_WU:            legal = !req_we && (XLEN == 64);
            default:          legal = 1'b0;
        endcase
        case (req_funct3[1:0])
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            2'd3:    misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
        dec_err = !legal ? ERR_FUNCT3 : (misaligned ? ERR_MISALIGN : ERR_NONE);
    end

    assign cnt_inc   = {1'b0, cnt_q} + 9'd1;
    assign timed_out = (cnt_inc >= 9'(TIMEOUT));

    // Next-state logic: request capture, handshake, timeout and completion
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    cnt_d   = '0;
                    err_d   = dec_err;
                    state_d = (dec_err == ERR_NONE) ? S_REQ : S_RESP;
                end
            end
            S_REQ: begin
                cnt_d = cnt_inc[7:0];
                if (mem_gnt && mem_rvalid) begin
                    rdata_d = we_q ? '0 : align_rdata;
                    state_d = S_RESP;
                end else if (timed_out) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_RESP;
                end else if (mem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc[7:0];
                if (mem_rvalid) begin
                    rdata_d = we_q ? '0 : align_rdata;
                    state_d = S_RESP;
                end else if (timed_out) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_RESP;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state: synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request/response payload registers
    always_ff @(posedge clk) begin
        // NOTE: payload is not reset; it is written on every accept before
        // it is used, and all outputs derived from it are gated by state.
        we_q    <= we_d;
        f3_q    <= f3_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
        err_q   <= err_d;
    end

    // Outputs are decoded from state so reset forces them to zero at once
    always_comb begin
        req_ready    = (state_q == S_IDLE);
        mem_req      = (state_q == S_REQ);
        mem_we       = mem_req && we_q;
        mem_addr     = mem_req ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
        mem_be       = mem_req ? align_be : '0;
        mem_wdata    = mem_we ? align_wdata : '0;
        rsp_valid    = (state_q == S_RESP);
        rsp_rdata    = rsp_valid ? rdata_q : '0;
        rsp_err_code = rsp_valid ? err_q : ERR_NONE;
        rsp_err      = rsp_valid && (err_q != ERR_NONE);
    end

endmodule
